// File: rtl/pipelinePkg.sv
// ---------------------------------------------------------------
// pipelinePkg : shared state encoding for the two-entry stage register
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package pipelinePkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

  function automatic logic [OCC_W-1:0] occupancy_of(input stage_state_e s);
    case (s)
      EMPTY:   occupancy_of = 2'd0;
      ONE:     occupancy_of = 2'd1;
      TWO:     occupancy_of = 2'd2;
      default: occupancy_of = 2'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/stageDataRegister.sv
// ---------------------------------------------------------------
// stageDataRegister : enable-loaded payload register, async active-low reset
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module stageDataRegister #(
  parameter int                    DATA_WIDTH = 65,
  parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] q_out
);

  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_en) data_d = d_in;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) data_q <= RESET_DATA;
    else        data_q <= data_d;
  end

  assign q_out = data_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_stage_register.sv
// ---------------------------------------------------------------
// pipeline_stage_register : valid/ready stage with a skid entry (full throughput)
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module pipeline_stage_register
  import pipelinePkg::*;
#(
  parameter int                    DATA_WIDTH = 65,
  parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [DATA_WIDTH-1:0] inData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] outData,
  input  logic                  flush,
  output logic [OCC_W-1:0]      occupancy
);

  stage_state_e          state_q;
  stage_state_e          state_d;
  logic                  main_load;
  logic                  skid_load;
  logic [DATA_WIDTH-1:0] main_in;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic                  in_fire;
  logic                  out_fire;

  // Handshake outputs come from the state register only, so inReady never
  // depends combinationally on outReady.
  assign outValid  = (state_q != EMPTY);
  assign inReady   = (state_q != TWO);
  assign outData   = main_q;
  assign occupancy = occupancy_of(state_q);

  assign in_fire  = inValid & inReady;
  assign out_fire = outValid & outReady;

  // Main refills from skid when draining TWO, otherwise from upstream.
  assign main_in = (state_q == TWO) ? skid_q : inData;

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = TWO;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  stageDataRegister #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_DATA (RESET_DATA)
  ) u_main (
    .clock   (clock),
    .reset   (reset),
    .load_en (main_load),
    .d_in    (main_in),
    .q_out   (main_q)
  );

  stageDataRegister #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_DATA (RESET_DATA)
  ) u_skid (
    .clock   (clock),
    .reset   (reset),
    .load_en (skid_load),
    .d_in    (inData),
    .q_out   (skid_q)
  );

endmodule

`default_nettype wire

// File: doc/pipeline_stage_register.md
PIPELINE_STAGE_REGISTER -- requirements
Module: pipeline_stage_register

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 65, the width of the payload carried between stages (e.g. 1 select bit + 32 memory data + 32 ALU data).
REQ-002 SHALL have parameter RESET_DATA, default all-zeros of DATA_WIDTH, the value loaded into both data registers at reset.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset (0 = in reset).
REQ-005 SHALL have port inValid, input, 1, upstream payload present.
REQ-006 SHALL have port inReady, output, 1, stage can accept a payload this cycle.
REQ-007 SHALL have port inData, input, DATA_WIDTH, upstream payload.
REQ-008 SHALL have port outValid, output, 1, payload presented downstream.
REQ-009 SHALL have port outReady, input, 1, downstream accepts (deasserted = stall).
REQ-010 SHALL have port outData, output, DATA_WIDTH, downstream payload.
REQ-011 SHALL have port flush, input, 1, synchronous kill of all held payloads (branch/exception).
REQ-012 SHALL have port occupancy, output, 2, number of held payloads (0..2).

Function
REQ-013 SHALL define inFire = inValid & inReady and outFire = outValid & outReady.
REQ-014 SHALL hold up to two payloads: a main register driving outData and a skid register.
REQ-015 SHALL use three states: EMPTY (occupancy 0), ONE (main full), TWO (main and skid full).
REQ-016 SHALL drive outValid = (state != EMPTY), outData = main register, and inReady = (state != TWO).
REQ-017 SHALL derive inReady from state registers only, with no combinational path from outReady.
REQ-018 In EMPTY: on inFire, main <= inData and the state goes to ONE; otherwise the state stays EMPTY.
REQ-019 In ONE: inFire & outFire -> main <= inData, stay ONE; inFire only -> skid <= inData, go TWO; outFire only -> go EMPTY; neither -> hold.
REQ-020 In TWO: on outFire, main <= skid and the state goes to ONE; otherwise hold, and inData is ignored.
REQ-021 SHALL deliver payloads in strict arrival order, with no loss or duplication absent flush.
REQ-022 Latency: a payload accepted into EMPTY SHALL appear on outValid/outData the next cycle.
REQ-023 Throughput: with outReady held high, SHALL accept and deliver one payload per cycle indefinitely.
REQ-024 When outReady is low, outValid and outData SHALL remain stable until outFire.
REQ-025 flush SHALL take priority over all other events: the next state is EMPTY and a concurrent inFire payload is discarded.
REQ-026 flush SHALL NOT clear the data registers; outData is don't-care whenever outValid = 0.
REQ-027 occupancy SHALL equal 0/1/2 for EMPTY/ONE/TWO, respectively.

Reset
REQ-028 While reset = 0, SHALL asynchronously force the state to EMPTY and both data registers to RESET_DATA.
REQ-029 During reset, outputs SHALL be outValid = 0, inReady = 1, outData = RESET_DATA, occupancy = 0.
REQ-030 On reset assertion mid-operation, all held payloads SHALL be lost, with no partial update.
REQ-031 Reset deassertion SHALL be synchronized externally, and the first transfer SHALL be permitted on the first rising edge after release.

Structure
REQ-032 SHALL place the state enum typedef (EMPTY/ONE/TWO) and the occupancy width constant in shared package pipelinePkg.
REQ-033 SHALL instantiate sub-module stageDataRegister (an enable-loaded, async-reset DATA_WIDTH register) twice, once for main and once for skid.
REQ-034 SHALL keep the next-state/load-enable logic in this module, combinational and separated from the registers.

Verification
REQ-035 Scenario 1: reset low, then high, then inValid = 1, inData = 0x1_DEADBEEF_00000010, outReady = 1 -> next cycle outValid = 1 with the same data, occupancy = 1.
REQ-036 Scenario 2: outReady = 0, send A = 0x11 then B = 0x22 -> occupancy = 2 and inReady = 0; C = 0x33 is held by upstream; then outReady = 1 -> outputs A, B, C in order on consecutive cycles.
REQ-037 Scenario 3: stream 16 payloads 0..15 with outReady = 1 -> 16 outFires on 16 consecutive cycles, in order, with inReady never 0.
REQ-038 Scenario 4: in TWO, assert flush together with inValid = 1, inData = 0x44 -> next cycle outValid = 0, occupancy = 0, and 0x44 is never delivered.
REQ-039 Scenario 5: in ONE with payload 0x55, pull reset low asynchronously between edges -> outValid = 0 and outData = 0 immediately, occupancy = 0.
REQ-040 Scenario 6: random inValid/outReady/flush for 10k cycles against a FIFO scoreboard -> no loss, duplication or reorder, and outData is stable under stall.
